window_mask_filter: RTL and testbench

- Consumes the 3x3 window of 28-bit pixel words produced by the 3-line buffer. Word layout: [27:4] RGB, [3] BLANK_N, [2] VS, [1] HS, [0] decision.
- Applies a selectable 3x3 binary morphological operation to the decision bits.
- Emits a re-timed VGA pixel stream with an optional mask overlay.
- Accumulates per-frame mask statistics (pixel count, bounding box) for the downstream tracking logic.

---
 rtl/pixel_pkg.sv | 41 ++++
 rtl/window_mask_filter_if.sv | 37 +++
 rtl/window_mask_filter_stats.sv | 73 +++++++
 rtl/window_mask_filter.sv | 147 ++++++++++++++
 tb/tb_window_mask_filter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the window mask filter: pixel word fields, filter
// modes, coordinate width and the empty bounding box.
package pixel_pkg;

    localparam int unsigned COORD_W   = 13;
    localparam int unsigned RGB_HI    = 27;
    localparam int unsigned RGB_LO    = 4;
    localparam int unsigned BLANK_BIT = 3;
    localparam int unsigned VS_BIT    = 2;
    localparam int unsigned HS_BIT    = 1;
    localparam int unsigned DEC_BIT   = 0;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_ERODE    = 2'b01,
        MODE_DILATE   = 2'b10,
        MODE_MAJORITY = 2'b11
    } mode_e;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x_min;
        coord_t x_max;
        coord_t y_min;
        coord_t y_max;
    } bbox_t;

    // Empty box: min at all-ones and max at zero so the first pixel sets both.
    localparam bbox_t BBOX_EMPTY = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] total;
        total = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            total = total + {3'b000, bits[k]};
        end
        return total;
    endfunction

endpackage

// File: rtl/window_mask_filter_if.sv
// Window-side inputs and re-timed video / statistics outputs of the filter.
// The master side feeds taps; the slave side is the filter itself.
interface window_mask_filter_if #(
    parameter int unsigned BUS_SIZE = 28,
    parameter int unsigned CNT_W    = 20
);

    logic                          EN;
    logic [BUS_SIZE-1:0]           win_x0y0, win_x1y0, win_x2y0;
    logic [BUS_SIZE-1:0]           win_x0y1, win_x1y1, win_x2y1;
    logic [BUS_SIZE-1:0]           win_x0y2, win_x1y2, win_x2y2;
    logic [pixel_pkg::COORD_W-1:0] row, col;
    logic [1:0]                    mode;
    logic                          overlay_en;

    logic [7:0]                    R_out, G_out, B_out;
    logic                          BLANK_N_out, VS_out, HS_out;
    logic                          mask_out;
    logic                          frame_valid;
    logic [CNT_W-1:0]              mask_count;
    logic [pixel_pkg::COORD_W-1:0] x_min, x_max, y_min, y_max;

    modport master (
        output EN, win_x0y0, win_x1y0, win_x2y0, win_x0y1, win_x1y1, win_x2y1,
               win_x0y2, win_x1y2, win_x2y2, row, col, mode, overlay_en,
        input  R_out, G_out, B_out, BLANK_N_out, VS_out, HS_out, mask_out,
               frame_valid, mask_count, x_min, x_max, y_min, y_max
    );

    modport slave (
        input  EN, win_x0y0, win_x1y0, win_x2y0, win_x0y1, win_x1y1, win_x2y1,
               win_x0y2, win_x1y2, win_x2y2, row, col, mode, overlay_en,
        output R_out, G_out, B_out, BLANK_N_out, VS_out, HS_out, mask_out,
               frame_valid, mask_count, x_min, x_max, y_min, y_max
    );

endinterface

// File: rtl/window_mask_filter_stats.sv
// Per-frame mask statistics: pixel count and bounding box, latched and
// restarted on each falling edge of the stage-2 vertical sync.
module mask_stats_accum
    import pixel_pkg::*;
#(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             mask,
    input  coord_t           row,
    input  coord_t           col,
    input  logic             vs,
    output logic             frame_valid,
    output logic [CNT_W-1:0] mask_count,
    output coord_t           x_min,
    output coord_t           x_max,
    output coord_t           y_min,
    output coord_t           y_max
);

    logic             vs_q;
    logic             frame_end;
    logic [CNT_W-1:0] acc_cnt, cnt_base, cnt_nxt;
    bbox_t            acc_box, box_base, box_nxt;

    // The pixel arriving with the VS fall opens the new frame, so it merges
    // into the freshly emptied accumulator rather than the one being reported.
    always_comb begin
        frame_end = en & vs_q & ~vs;
        cnt_base  = frame_end ? '0 : acc_cnt;
        box_base  = frame_end ? BBOX_EMPTY : acc_box;
        cnt_nxt   = cnt_base;
        box_nxt   = box_base;
        if (mask) begin
            if (cnt_base != '1) cnt_nxt = cnt_base + CNT_W'(1);
            if (col < box_base.x_min) box_nxt.x_min = col;
            if (col > box_base.x_max) box_nxt.x_max = col;
            if (row < box_base.y_min) box_nxt.y_min = row;
            if (row > box_base.y_max) box_nxt.y_max = row;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_q        <= 1'b1;
            acc_cnt     <= '0;
            acc_box     <= BBOX_EMPTY;
            frame_valid <= 1'b0;
            mask_count  <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
        end else begin
            frame_valid <= frame_end;
            if (en) begin
                vs_q    <= vs;
                acc_cnt <= cnt_nxt;
                acc_box <= box_nxt;
                if (frame_end) begin
                    mask_count <= acc_cnt;
                    x_min      <= acc_box.x_min;
                    x_max      <= acc_box.x_max;
                    y_min      <= acc_box.y_min;
                    y_max      <= acc_box.y_max;
                end
            end
        end
    end

endmodule

// File: rtl/window_mask_filter.sv
// 3x3 binary morphology on the decision bits of a pixel window, re-timed VGA
// output with optional mask overlay, and per-frame mask statistics.
module window_mask_filter
    import pixel_pkg::*;
#(
    parameter int unsigned BUS_SIZE  = 28,
    parameter int unsigned MAJ_THRES = 5,
    parameter int unsigned CNT_W     = 20,
    parameter logic [23:0] OVL_RGB   = 24'hFF00FF
) (
    input logic                 clock,
    input logic                 reset_n,
    window_mask_filter_if.slave bus
);

    localparam logic [3:0] MAJ_T = 4'(MAJ_THRES);

    logic [BUS_SIZE-1:0] taps [9];
    logic [8:0]          eff;
    logic                unused_tap_bits;

    assign taps[0] = bus.win_x0y0;
    assign taps[1] = bus.win_x1y0;
    assign taps[2] = bus.win_x2y0;
    assign taps[3] = bus.win_x0y1;
    assign taps[4] = bus.win_x1y1;
    assign taps[5] = bus.win_x2y1;
    assign taps[6] = bus.win_x0y2;
    assign taps[7] = bus.win_x1y2;
    assign taps[8] = bus.win_x2y2;

    // Blanked taps count as clear, so erode trims the active-area border.
    always_comb begin
        eff             = '0;
        unused_tap_bits = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            eff[k] = taps[k][DEC_BIT] & taps[k][BLANK_BIT];
            if (k != 4) begin
                unused_tap_bits = unused_tap_bits ^
                    (^{taps[k][RGB_HI:RGB_LO], taps[k][VS_BIT], taps[k][HS_BIT]});
            end
        end
    end

    logic [3:0]  s1_cnt;
    logic        s1_ctr;
    logic [23:0] s1_rgb;
    logic        s1_blank, s1_vs, s1_hs;
    coord_t      s1_row, s1_col;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_cnt   <= '0;
            s1_ctr   <= 1'b0;
            s1_rgb   <= '0;
            s1_blank <= 1'b0;
            s1_vs    <= 1'b1;
            s1_hs    <= 1'b1;
            s1_row   <= '0;
            s1_col   <= '0;
        end else if (bus.EN) begin
            s1_cnt   <= popcount9(eff);
            s1_ctr   <= eff[4];
            s1_rgb   <= taps[4][RGB_HI:RGB_LO];
            s1_blank <= taps[4][BLANK_BIT];
            s1_vs    <= taps[4][VS_BIT];
            s1_hs    <= taps[4][HS_BIT];
            s1_row   <= bus.row;
            s1_col   <= bus.col;
        end
    end

    mode_e       mode_s;
    logic        filt, mask_nxt;
    logic [23:0] rgb_nxt;

    assign mode_s = mode_e'(bus.mode);

    always_comb begin
        filt = 1'b0;
        unique case (mode_s)
            MODE_PASS:     filt = s1_ctr;
            MODE_ERODE:    filt = (s1_cnt == 4'd9);
            MODE_DILATE:   filt = (s1_cnt != 4'd0);
            MODE_MAJORITY: filt = (s1_cnt >= MAJ_T);
        endcase
        mask_nxt = filt & s1_blank;
        rgb_nxt  = (bus.overlay_en & mask_nxt) ? OVL_RGB : s1_rgb;
    end

    logic [23:0] out_rgb;
    logic        out_blank, out_vs, out_hs, out_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_rgb   <= '0;
            out_blank <= 1'b0;
            out_vs    <= 1'b1;
            out_hs    <= 1'b1;
            out_mask  <= 1'b0;
        end else if (bus.EN) begin
            out_rgb   <= rgb_nxt;
            out_blank <= s1_blank;
            out_vs    <= s1_vs;
            out_hs    <= s1_hs;
            out_mask  <= mask_nxt;
        end
    end

    assign bus.R_out       = out_rgb[23:16];
    assign bus.G_out       = out_rgb[15:8];
    assign bus.B_out       = out_rgb[7:0];
    assign bus.BLANK_N_out = out_blank;
    assign bus.VS_out      = out_vs;
    assign bus.HS_out      = out_hs;
    assign bus.mask_out    = out_mask;

    logic             st_valid;
    logic [CNT_W-1:0] st_count;
    coord_t           st_xmin, st_xmax, st_ymin, st_ymax;

    mask_stats_accum #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clock       (clock),
        .reset_n     (reset_n),
        .en          (bus.EN),
        .mask        (mask_nxt),
        .row         (s1_row),
        .col         (s1_col),
        .vs          (s1_vs),
        .frame_valid (st_valid),
        .mask_count  (st_count),
        .x_min       (st_xmin),
        .x_max       (st_xmax),
        .y_min       (st_ymin),
        .y_max       (st_ymax)
    );

    assign bus.frame_valid = st_valid;
    assign bus.mask_count  = st_count;
    assign bus.x_min       = st_xmin;
    assign bus.x_max       = st_xmax;
    assign bus.y_min       = st_ymin;
    assign bus.y_max       = st_ymax;

endmodule

// File: tb/tb_window_mask_filter.sv
// Directed bench for window_mask_filter: a table of single-window vectors,
// then synthetic frames checked pixel by pixel and by frame statistics.
module tb_window_mask_filter;
    import pixel_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    window_mask_filter_if #(.BUS_SIZE(28), .CNT_W(20)) bus();

    window_mask_filter #(
        .BUS_SIZE  (28),
        .MAJ_THRES (5),
        .CNT_W     (20),
        .OVL_RGB   (24'hFF00FF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [27:0] exp_q[$];
    int          fv_cnt;
    logic [19:0] cap_cnt;
    logic [12:0] cap_xmin, cap_xmax, cap_ymin, cap_ymax;

    typedef struct {
        logic [8:0]  dec;
        logic [8:0]  blk;
        logic [1:0]  mode;
        logic        ovl;
        logic [23:0] rgb;
        logic        vs;
        logic        hs;
        logic        mask;
        logic [23:0] rgb_exp;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] out_tuple();
        return {bus.R_out, bus.G_out, bus.B_out, bus.BLANK_N_out, bus.VS_out, bus.HS_out, bus.mask_out};
    endfunction

    task automatic chk_reset(input string name);
        check({name, "_rgb"}, {bus.R_out, bus.G_out, bus.B_out}, 24'h0);
        check({name, "_sync"}, {bus.BLANK_N_out, bus.VS_out, bus.HS_out, bus.mask_out, bus.frame_valid}, 5'b01100);
        check({name, "_stats"}, {bus.mask_count, bus.x_min, bus.x_max, bus.y_min, bus.y_max}, 64'h0);
    endtask

    task automatic drive_taps(input logic [8:0] dec, input logic [8:0] blk, input logic vs, input logic hs,
                              input logic [23:0] rgb, input logic [12:0] r, input logic [12:0] c);
        logic [27:0] w [9];
        for (int k = 0; k < 9; k++) w[k] = {(k == 4) ? rgb : 24'hA5A5A5, blk[k], vs, hs, dec[k]};
        bus.win_x0y0 = w[0]; bus.win_x1y0 = w[1]; bus.win_x2y0 = w[2];
        bus.win_x0y1 = w[3]; bus.win_x1y1 = w[4]; bus.win_x2y1 = w[5];
        bus.win_x0y2 = w[6]; bus.win_x1y2 = w[7]; bus.win_x2y2 = w[8];
        bus.row = r;
        bus.col = c;
    endtask

    // One enabled pixel; the output two enabled cycles later is compared
    // against the expectation queued for it. With tog, an EN=0 cycle follows.
    task automatic px(input logic [8:0] dec, input logic [8:0] blk, input logic vs, input logic hs,
                      input logic [23:0] rgb, input logic [12:0] r, input logic [12:0] c,
                      input logic em, input bit tog);
        logic [27:0] e, last;
        e = {(em && bus.overlay_en) ? 24'hFF00FF : rgb, blk[4], vs, hs, em};
        drive_taps(dec, blk, vs, hs, rgb, r, c);
        bus.EN = 1'b1;
        exp_q.push_back(e);
        step();
        if (bus.frame_valid) begin
            fv_cnt++;
            cap_cnt  = bus.mask_count;
            cap_xmin = bus.x_min; cap_xmax = bus.x_max;
            cap_ymin = bus.y_min; cap_ymax = bus.y_max;
        end
        if (exp_q.size() >= 2) check("pixel", out_tuple(), exp_q.pop_front());
        if (tog) begin
            last = out_tuple();
            bus.EN = 1'b0;
            drive_taps(9'h1FF, 9'h1FF, 1'b0, 1'b0, 24'h123456, r + 13'd5, c + 13'd5);
            step();
            check("hold", {out_tuple(), bus.frame_valid}, {last, 1'b0});
        end
    endtask

    function automatic bit img(input int kind, input int r, input int c);
        if (kind == 1) return (r == 50 && c == 100);
        if (kind == 2) return (r >= 20 && r <= 24 && c >= 30 && c <= 34);
        return 1'b0;
    endfunction

    function automatic logic exp_rule(input int ek, input int r, input int c);
        bit corner;
        if (ek == 1) return (r >= 49 && r <= 51 && c >= 99 && c <= 101);
        if (ek == 2) begin
            corner = (r == 20 || r == 24) && (c == 30 || c == 34);
            return (r >= 20 && r <= 24 && c >= 30 && c <= 34) && !corner;
        end
        return 1'b0;
    endfunction

    task automatic run_active(input int kind, input int ek, input int r0, input int r1,
                              input int c0, input int c1, input bit tog);
        logic [8:0] dec;
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                for (int y = 0; y < 3; y++)
                    for (int x = 0; x < 3; x++)
                        dec[3*y+x] = img(kind, r + y - 1, c + x - 1);
                px(dec, 9'h1FF, 1'b1, 1'b1, {8'(r), 8'(c), 8'h5A}, 13'(r), 13'(c), exp_rule(ek, r, c), tog);
            end
        end
    endtask

    task automatic run_vsync(input bit tog);
        for (int i = 0; i < 3; i++) px(9'h0, 9'h0, 1'b0, 1'b1, 24'h0, 13'd0, 13'd0, 1'b0, tog);
        for (int i = 0; i < 2; i++) px(9'h0, 9'h0, 1'b1, 1'b1, 24'h0, 13'd0, 13'd0, 1'b0, tog);
    endtask

    task automatic chk_frame(input string name, input logic [19:0] cnt, input logic [12:0] xmin,
                             input logic [12:0] xmax, input logic [12:0] ymin, input logic [12:0] ymax);
        check({name, "_pulses"}, fv_cnt, 1);
        check({name, "_count"}, cap_cnt, cnt);
        check({name, "_x"}, {cap_xmin, cap_xmax}, {xmin, xmax});
        check({name, "_y"}, {cap_ymin, cap_ymax}, {ymin, ymax});
        check({name, "_count_held"}, bus.mask_count, cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //           dec     blk     mode   ovl  rgb         vs    hs    mask  rgb_exp
        tbl[0]  = '{9'h010, 9'h1FF, 2'b00, 1'b0, 24'h123456, 1'b1, 1'b1, 1'b1, 24'h123456};
        tbl[1]  = '{9'h010, 9'h1FF, 2'b01, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b0, 24'h123456};
        tbl[2]  = '{9'h010, 9'h1FF, 2'b10, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
        tbl[3]  = '{9'h1FF, 9'h1FF, 2'b01, 1'b0, 24'hABCDEF, 1'b0, 1'b1, 1'b1, 24'hABCDEF};
        tbl[4]  = '{9'h1FF, 9'h1FE, 2'b01, 1'b1, 24'hABCDEF, 1'b1, 1'b1, 1'b0, 24'hABCDEF};
        tbl[5]  = '{9'h0F0, 9'h1FF, 2'b11, 1'b1, 24'h010203, 1'b1, 1'b1, 1'b0, 24'h010203};
        tbl[6]  = '{9'h1F0, 9'h1FF, 2'b11, 1'b1, 24'h010203, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
        tbl[7]  = '{9'h0F0, 9'h1FF, 2'b00, 1'b0, 24'h445566, 1'b1, 1'b0, 1'b1, 24'h445566};
        tbl[8]  = '{9'h1FF, 9'h1EF, 2'b10, 1'b1, 24'h777777, 1'b1, 1'b1, 1'b0, 24'h777777};
        tbl[9]  = '{9'h001, 9'h1FF, 2'b00, 1'b1, 24'h0A0B0C, 1'b1, 1'b1, 1'b0, 24'h0A0B0C};
        tbl[10] = '{9'h001, 9'h1FF, 2'b10, 1'b1, 24'h0A0B0C, 1'b1, 1'b1, 1'b1, 24'hFF00FF};
        tbl[11] = '{9'h000, 9'h1FF, 2'b10, 1'b1, 24'h0A0B0C, 1'b0, 1'b0, 1'b0, 24'h0A0B0C};
        tbl[12] = '{9'h1EF, 9'h1FF, 2'b11, 1'b0, 24'h303030, 1'b1, 1'b1, 1'b1, 24'h303030};
        tbl[13] = '{9'h1EF, 9'h1FF, 2'b00, 1'b0, 24'h303030, 1'b1, 1'b1, 1'b0, 24'h303030};
        tbl[14] = '{9'h1F0, 9'h0FF, 2'b11, 1'b1, 24'h999999, 1'b1, 1'b1, 1'b0, 24'h999999};

        bus.EN = 1'b0;
        bus.mode = 2'b00;
        bus.overlay_en = 1'b0;
        drive_taps(9'h0, 9'h0, 1'b1, 1'b1, 24'h0, 13'd0, 13'd0);
        repeat (2) step();
        chk_reset("init");
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            bus.mode = tbl[i].mode;
            bus.overlay_en = tbl[i].ovl;
            drive_taps(tbl[i].dec, tbl[i].blk, tbl[i].vs, tbl[i].hs, tbl[i].rgb, 13'(i), 13'(i));
            bus.EN = 1'b1;
            step();
            step();
            check($sformatf("vec%0d", i), out_tuple(),
                  {tbl[i].rgb_exp, tbl[i].blk[4], tbl[i].vs, tbl[i].hs, tbl[i].mask});
        end

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q.delete();

        // Frame A: single pixel dilated to a 3x3 block.
        bus.mode = 2'b10; bus.overlay_en = 1'b0; fv_cnt = 0;
        run_active(1, 1, 48, 52, 98, 102, 1'b0);
        run_vsync(1'b0);
        chk_frame("A", 20'd9, 13'd99, 13'd101, 13'd49, 13'd51);

        // Frame B: same pixel eroded away, empty statistics.
        bus.mode = 2'b01; fv_cnt = 0;
        run_active(1, 0, 48, 52, 98, 102, 1'b0);
        run_vsync(1'b0);
        chk_frame("B", 20'd0, 13'h1FFF, 13'd0, 13'h1FFF, 13'd0);

        // Frame C: 5x5 block, majority, overlay on; corners drop out.
        bus.mode = 2'b11; bus.overlay_en = 1'b1; fv_cnt = 0;
        run_active(2, 2, 18, 26, 28, 36, 1'b0);
        run_vsync(1'b0);
        chk_frame("C", 20'd21, 13'd30, 13'd34, 13'd20, 13'd24);

        // Frame D: frame A again with EN toggling every cycle.
        bus.mode = 2'b10; bus.overlay_en = 1'b0; fv_cnt = 0;
        run_active(1, 1, 48, 52, 98, 102, 1'b1);
        run_vsync(1'b1);
        chk_frame("D", 20'd9, 13'd99, 13'd101, 13'd49, 13'd51);

        // Masked pixel on the VS-fall cycle belongs to the following frame.
        bus.mode = 2'b00; fv_cnt = 0;
        px(9'h1FF, 9'h1FF, 1'b0, 1'b1, 24'hC0FFEE, 13'd7, 13'd9, 1'b1, 1'b0);
        run_vsync(1'b0);
        chk_frame("E_prev", 20'd0, 13'h1FFF, 13'd0, 13'h1FFF, 13'd0);
        fv_cnt = 0;
        run_active(0, 0, 5, 6, 5, 6, 1'b0);
        run_vsync(1'b0);
        chk_frame("E_next", 20'd1, 13'd9, 13'd9, 13'd7, 13'd7);

        // Reset mid-frame: async clear, then only post-reset pixels count.
        bus.mode = 2'b10; fv_cnt = 0;
        run_active(1, 1, 48, 50, 98, 102, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_reset("async");
        repeat (3) step();
        chk_reset("held");
        #2 reset_n = 1'b1;
        exp_q.delete();
        fv_cnt = 0;
        run_active(1, 1, 51, 52, 98, 102, 1'b0);
        run_vsync(1'b0);
        chk_frame("F", 20'd3, 13'd99, 13'd101, 13'd51, 13'd51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
